// File: rtl/cache_fill_responder_pkg.sv
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared line geometry and FSM state encoding for the fill responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

   localparam int c_BURSTLOG2 = 3;
   localparam int c_LINEWORDS = 2 ** c_BURSTLOG2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/cache_fill_responder_if.sv
// ============================================================================
// Module   : cache_fill_responder_if
// Brief    : Cache-side fill handshake and backing-memory read port bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_fill_responder_if #(
   parameter int ADDRWIDTH = 32
);
   logic                 sdram_req;
   logic [ADDRWIDTH-1:0] sdram_addr;
   logic                 sdram_fill;
   logic [31:0]          sdram_data;
   logic                 busy;
   logic                 mem_req;
   logic [ADDRWIDTH-1:0] mem_addr;
   logic                 mem_ack;
   logic [31:0]          mem_q;

   // master: the cache plus backing memory environment
   modport master (
      output sdram_req, sdram_addr, mem_ack, mem_q,
      input  sdram_fill, sdram_data, busy, mem_req, mem_addr
   );

   // slave: the fill responder
   modport slave (
      input  sdram_req, sdram_addr, mem_ack, mem_q,
      output sdram_fill, sdram_data, busy, mem_req, mem_addr
   );
endinterface

`default_nettype wire

// File: rtl/cache_fill_responder_line_buffer.sv
// ============================================================================
// Module   : line_buffer
// Brief    : N x 32 line store, one write port and one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer
   import cache_pkg::*;
#(
   parameter int BURSTLOG2 = c_BURSTLOG2
) (
   input  wire logic                 clk,
   input  wire logic                 reset,
   input  wire logic                 we,
   input  wire logic [BURSTLOG2-1:0] windex,
   input  wire logic [31:0]          wdata,
   input  wire logic                 re,
   input  wire logic [BURSTLOG2-1:0] rindex,
   output      logic [31:0]          rdata
);

   logic [31:0] r_mem [2**BURSTLOG2];
   logic [31:0] r_rdata;

   // Storage needs no reset: every line is fully rewritten before it is read.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[windex] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata <= '0;
      end else if (re) begin
         r_rdata <= r_mem[rindex];
      end
   end

   assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/cache_fill_responder.sv
// ============================================================================
// Module   : cache_fill_responder
// Brief    : Fetches a cache line critical-word-first, then bursts it gaplessly.
//            Optional CACHE_FILL_RESPONDER_PERF_EN adds fill/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_responder
   import cache_pkg::*;
#(
   parameter int BURSTLOG2 = c_BURSTLOG2,
   parameter int ADDRWIDTH = 32
) (
   input  wire logic             clk,
   input  wire logic             reset,
   cache_fill_responder_if.slave bus
`ifdef CACHE_FILL_RESPONDER_PERF_EN
   ,
   output      logic [31:0]      perf_fills,
   output      logic [31:0]      perf_stalls
`endif
);

   // BURSTLOG2 must be at least 1 so buf[0] is never written on the final ack.
   localparam int                   c_N    = 2 ** BURSTLOG2;
   localparam int                   c_BW   = ADDRWIDTH - BURSTLOG2 - 2;
   localparam logic [BURSTLOG2-1:0] c_LAST = BURSTLOG2'(c_N - 1);

   state_t                 r_state;
   logic [c_BW-1:0]        r_base;
   logic [BURSTLOG2-1:0]   r_idx;
   logic [BURSTLOG2-1:0]   r_cnt;
   logic                   r_fill;
   logic                   r_busy;
   logic                   r_mem_req;
   logic [ADDRWIDTH-1:0]   r_mem_addr;

   logic                   w_ack;
   logic [BURSTLOG2-1:0]   w_idx_next;
   logic                   w_re;
   logic [BURSTLOG2-1:0]   w_rindex;
   logic [31:0]            w_rdata;
   logic [1:0]             w_unused_byte;

   assign w_ack         = (r_state == FETCH) && r_mem_req && bus.mem_ack;
   assign w_idx_next    = r_idx + BURSTLOG2'(1);
   assign w_unused_byte = bus.sdram_addr[1:0];

   // Read one word ahead so each stream word is already registered when shown.
   assign w_re     = (w_ack && (r_cnt == c_LAST)) ||
                     ((r_state == STREAM) && (r_cnt != c_LAST));
   assign w_rindex = (r_state == STREAM) ? (r_cnt + BURSTLOG2'(1)) : '0;

   line_buffer #(
      .BURSTLOG2 (BURSTLOG2)
   ) u_line_buffer (
      .clk    (clk),
      .reset  (reset),
      .we     (w_ack),
      .windex (r_cnt),
      .wdata  (bus.mem_q),
      .re     (w_re),
      .rindex (w_rindex),
      .rdata  (w_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_fill     <= 1'b0;
         r_busy     <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         r_fill <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.sdram_req) begin
                  r_base     <= bus.sdram_addr[ADDRWIDTH-1:BURSTLOG2+2];
                  r_idx      <= bus.sdram_addr[BURSTLOG2+1:2];
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= {bus.sdram_addr[ADDRWIDTH-1:2], 2'b00};
                  r_state    <= FETCH;
               end
            end
            FETCH: begin
               if (w_ack) begin
                  r_cnt      <= r_cnt + BURSTLOG2'(1);
                  r_idx      <= w_idx_next;
                  r_mem_addr <= {r_base, w_idx_next, 2'b00};
                  if (r_cnt == c_LAST) begin
                     r_mem_req <= 1'b0;
                     r_cnt     <= '0;
                     r_fill    <= 1'b1;
                     r_state   <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (r_cnt == c_LAST) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + BURSTLOG2'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_FILL_RESPONDER_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fills  <= '0;
         perf_stalls <= '0;
      end else begin
         if ((r_state == STREAM) && (r_cnt == c_LAST)) begin
            perf_fills <= perf_fills + 32'd1;
         end
         if ((r_state == FETCH) && r_mem_req && !bus.mem_ack) begin
            perf_stalls <= perf_stalls + 32'd1;
         end
      end
   end
`endif

   assign bus.sdram_fill = r_fill;
   assign bus.sdram_data = w_rdata;
   assign bus.busy       = r_busy;
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_addr   = r_mem_addr;

endmodule

`default_nettype wire
